// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the CPU control path: PC width and sequencer state encoding.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cpu_ctrl_pkg;

    localparam int PC_W = 16;

    // Encoding is visible on the sequencer's state output, so values are fixed.
    typedef enum logic [1:0] {
        ST_INIT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STALL = 2'b10,
        ST_HALT  = 2'b11
    } seq_state_t;

endpackage

// File: rtl/pc_target_calc.sv
// Candidate next-PC values (sequential, PC-relative branch, absolute jump) plus jump misalignment flag.
// Latency: purely combinational.
// Backpressure: none; the sequencer decides which candidate to load.
module pc_target_calc
    import cpu_ctrl_pkg::*;
#(
    parameter int INSTR_BYTES = 2
) (
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] branch_offset,
    input  logic [PC_W-1:0] jump_target,
    output logic [PC_W-1:0] seq_pc,
    output logic [PC_W-1:0] branch_pc,
    output logic [PC_W-1:0] jump_pc,
    output logic            misalign
);

    localparam logic [PC_W-1:0] INC = PC_W'(INSTR_BYTES);

    // Word offset to byte offset; bit 15 falls off the top, all sums wrap modulo 2^16.
    logic [PC_W-1:0] offset_bytes;

    // Candidate computation; the jump target is forced to an even address.
    always_comb begin
        offset_bytes = branch_offset << 1;
        seq_pc       = pc + INC;
        branch_pc    = seq_pc + offset_bytes;
        jump_pc      = {jump_target[PC_W-1:1], 1'b0};
        misalign     = jump_target[0];
    end

endmodule

// File: rtl/branch_pc_sequencer.sv
// Program counter owner: picks sequential / branch / jump fetch address each cycle, handles stall and halt.
// Latency: one cycle from redirect inputs to new pc; pc_plus is combinational from pc.
// Backpressure: stall holds pc (inputs ignored while stalled); halt freezes until reset. Optional BRANCH_STATS_EN adds outcome counters.
module branch_pc_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter int          INSTR_BYTES  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        halt,
    input  logic        branch_en,
    input  logic        branch_cond,
    input  logic [15:0] branch_offset,
    input  logic        jump_en,
    input  logic [15:0] jump_target,
    output logic [15:0] pc,
    output logic [15:0] pc_plus,
    output logic        pc_valid,
    output logic        branch_taken,
    output logic        misalign_err,
    output logic [1:0]  state
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0] taken_cnt,
    output logic [15:0] not_taken_cnt
`endif
);

    seq_state_t      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            taken_q, taken_d;
    logic            mis_q, mis_d;
    logic            advance;

    logic [PC_W-1:0] seq_pc, branch_pc, jump_pc;
    logic            misalign;

    pc_target_calc #(
        .INSTR_BYTES (INSTR_BYTES)
    ) u_calc (
        .pc            (pc_q),
        .branch_offset (branch_offset),
        .jump_target   (jump_target),
        .seq_pc        (seq_pc),
        .branch_pc     (branch_pc),
        .jump_pc       (jump_pc),
        .misalign      (misalign)
    );

    // Next-state and next-PC selection: halt > stall > jump > taken branch > sequential.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        taken_d = 1'b0;
        mis_d   = mis_q;
        advance = 1'b0;
        case (state_q)
            ST_INIT: state_d = ST_RUN;
            ST_RUN, ST_STALL: begin
                if (halt) begin
                    state_d = ST_HALT;
                end else if (stall) begin
                    state_d = ST_STALL;
                end else begin
                    // Leaving STALL honours this cycle's redirect inputs just like RUN.
                    state_d = ST_RUN;
                    advance = 1'b1;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_INIT;
        endcase
        if (advance) begin
            if (jump_en) begin
                pc_d = jump_pc;
                if (misalign) begin
                    mis_d = 1'b1;
                end
            end else if (branch_en && branch_cond) begin
                pc_d    = branch_pc;
                taken_d = 1'b1;
            end else begin
                pc_d = seq_pc;
            end
        end
    end

    // State, PC and status registers; reset drops any redirect in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            pc_q    <= RESET_VECTOR;
            taken_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
            mis_q   <= mis_d;
        end
    end

    assign pc           = pc_q;
    assign pc_plus      = seq_pc;
    assign pc_valid     = (state_q == ST_RUN) || (state_q == ST_STALL);
    assign branch_taken = taken_q;
    assign misalign_err = mis_q;
    assign state        = state_q;

`ifdef BRANCH_STATS_EN
    logic [15:0] taken_cnt_q, not_taken_cnt_q;
    logic        count_br;

    // Only branches that actually execute are counted; a jump on the same cycle suppresses the branch.
    assign count_br = advance && branch_en && !jump_en;

    // Saturating outcome counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt_q     <= 16'h0000;
            not_taken_cnt_q <= 16'h0000;
        end else if (count_br) begin
            if (branch_cond && (taken_cnt_q != 16'hFFFF)) begin
                taken_cnt_q <= taken_cnt_q + 16'h0001;
            end
            if (!branch_cond && (not_taken_cnt_q != 16'hFFFF)) begin
                not_taken_cnt_q <= not_taken_cnt_q + 16'h0001;
            end
        end
    end

    assign taken_cnt     = taken_cnt_q;
    assign not_taken_cnt = not_taken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_pc_sequencer.sv
module tb_branch_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, halt, branch_en, branch_cond, jump_en;
    logic [15:0] branch_offset, jump_target;
    logic [15:0] pc, pc_plus;
    logic        pc_valid, branch_taken, misalign_err;
    logic [1:0]  state;
`ifdef BRANCH_STATS_EN
    logic [15:0] taken_cnt, not_taken_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_pc_sequencer #(
        .RESET_VECTOR (16'h0100),
        .INSTR_BYTES  (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .halt          (halt),
        .branch_en     (branch_en),
        .branch_cond   (branch_cond),
        .branch_offset (branch_offset),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .pc            (pc),
        .pc_plus       (pc_plus),
        .pc_valid      (pc_valid),
        .branch_taken  (branch_taken),
        .misalign_err  (misalign_err),
        .state         (state)
`ifdef BRANCH_STATS_EN
        ,
        .taken_cnt     (taken_cnt),
        .not_taken_cnt (not_taken_cnt)
`endif
    );

    typedef struct {
        logic        stall;
        logic        halt;
        logic        br_en;
        logic        cond;
        logic [15:0] off;
        logic        j_en;
        logic [15:0] jt;
        logic [15:0] e_pc;
        logic [1:0]  e_state;
        logic        e_valid;
        logic        e_bt;
        logic        e_mis;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic st, input logic hl, input logic be, input logic bc,
                                input logic [15:0] of, input logic je, input logic [15:0] jt,
                                input logic [15:0] epc, input logic [1:0] es, input logic ev,
                                input logic ebt, input logic emis);
        vec_t v;
        v.stall = st; v.halt = hl; v.br_en = be; v.cond = bc; v.off = of;
        v.j_en = je; v.jt = jt; v.e_pc = epc; v.e_state = es; v.e_valid = ev;
        v.e_bt = ebt; v.e_mis = emis;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic hl, input logic be, input logic bc,
                         input logic [15:0] of, input logic je, input logic [15:0] jt);
        stall = st; halt = hl; branch_en = be; branch_cond = bc;
        branch_offset = of; jump_en = je; jump_target = jt;
    endtask

    initial begin
        //               st hl be bc off       je jt        pc        state  v  bt mis
        vecs[0]  = mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0100, 2'b01, 1, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0102, 2'b01, 1, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0104, 2'b01, 1, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 16'h0000, 1, 16'h0010, 16'h0010, 2'b01, 1, 0, 0);
        vecs[4]  = mk(0, 0, 1, 1, 16'h0005, 0, 16'h0000, 16'h001C, 2'b01, 1, 1, 0);
        vecs[5]  = mk(0, 0, 0, 0, 16'h0000, 1, 16'h0010, 16'h0010, 2'b01, 1, 0, 0);
        vecs[6]  = mk(0, 0, 1, 0, 16'h0005, 0, 16'h0000, 16'h0012, 2'b01, 1, 0, 0);
        vecs[7]  = mk(0, 0, 0, 0, 16'h0000, 1, 16'h0010, 16'h0010, 2'b01, 1, 0, 0);
        vecs[8]  = mk(0, 0, 1, 1, 16'hFFF8, 0, 16'h0000, 16'h0002, 2'b01, 1, 1, 0);
        vecs[9]  = mk(0, 0, 0, 0, 16'h0000, 1, 16'hFFFE, 16'hFFFE, 2'b01, 1, 0, 0);
        vecs[10] = mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 2'b01, 1, 0, 0);
        vecs[11] = mk(0, 0, 1, 1, 16'h0005, 1, 16'h1235, 16'h1234, 2'b01, 1, 0, 1);
        vecs[12] = mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h1236, 2'b01, 1, 0, 1);
        vecs[13] = mk(0, 0, 1, 0, 16'h0005, 0, 16'h0000, 16'h1238, 2'b01, 1, 0, 1);
        vecs[14] = mk(0, 0, 0, 0, 16'h0000, 1, 16'h0040, 16'h0040, 2'b01, 1, 0, 1);
        vecs[15] = mk(1, 0, 1, 1, 16'h0005, 0, 16'h0000, 16'h0040, 2'b10, 1, 0, 1);
        vecs[16] = mk(1, 0, 1, 1, 16'h0005, 1, 16'h0200, 16'h0040, 2'b10, 1, 0, 1);
        vecs[17] = mk(1, 0, 1, 1, 16'h0005, 0, 16'h0000, 16'h0040, 2'b10, 1, 0, 1);
        vecs[18] = mk(0, 0, 1, 1, 16'h0002, 0, 16'h0000, 16'h0046, 2'b01, 1, 1, 1);
        vecs[19] = mk(0, 0, 0, 0, 16'h0000, 1, 16'h0080, 16'h0080, 2'b01, 1, 0, 1);
        vecs[20] = mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0080, 2'b11, 0, 0, 1);
        vecs[21] = mk(0, 0, 0, 0, 16'h0000, 1, 16'h0000, 16'h0080, 2'b11, 0, 0, 1);
        vecs[22] = mk(0, 0, 1, 1, 16'h0005, 0, 16'h0000, 16'h0080, 2'b11, 0, 0, 1);

        // Reset state
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 16'h0000, 0, 16'h0000);
        repeat (2) @(negedge clk);
        check("rst_pc", pc, 16'h0100);
        check("rst_state", {14'd0, state}, 16'h0000);
        check("rst_valid", {15'd0, pc_valid}, 16'h0000);
        check("rst_bt", {15'd0, branch_taken}, 16'h0000);
        check("rst_mis", {15'd0, misalign_err}, 16'h0000);
        rst_n = 1'b1;
        #1;
        check("init_pc", pc, 16'h0100);
        check("init_valid", {15'd0, pc_valid}, 16'h0000);

        // Table-driven main sequence, one vector per clock
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].stall, vecs[i].halt, vecs[i].br_en, vecs[i].cond,
                  vecs[i].off, vecs[i].j_en, vecs[i].jt);
            @(negedge clk);
            check($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
            check($sformatf("v%0d_pc_plus", i), pc_plus, vecs[i].e_pc + 16'h0002);
            check($sformatf("v%0d_state", i), {14'd0, state}, {14'd0, vecs[i].e_state});
            check($sformatf("v%0d_valid", i), {15'd0, pc_valid}, {15'd0, vecs[i].e_valid});
            check($sformatf("v%0d_bt", i), {15'd0, branch_taken}, {15'd0, vecs[i].e_bt});
            check($sformatf("v%0d_mis", i), {15'd0, misalign_err}, {15'd0, vecs[i].e_mis});
        end

`ifdef BRANCH_STATS_EN
        check("taken_cnt", taken_cnt, 16'd3);
        check("not_taken_cnt", not_taken_cnt, 16'd2);
`endif

        // Asynchronous reset mid-cycle, with a taken branch presented
        drive(0, 0, 1, 1, 16'h0005, 0, 16'h0000);
        #2 rst_n = 1'b0;
        #1;
        check("arst_pc", pc, 16'h0100);
        check("arst_state", {14'd0, state}, 16'h0000);
        check("arst_valid", {15'd0, pc_valid}, 16'h0000);
        check("arst_mis", {15'd0, misalign_err}, 16'h0000);
`ifdef BRANCH_STATS_EN
        check("arst_taken_cnt", taken_cnt, 16'd0);
        check("arst_not_taken_cnt", not_taken_cnt, 16'd0);
`endif
        @(negedge clk);
        drive(0, 0, 0, 0, 16'h0000, 0, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        check("rerun_state", {14'd0, state}, 16'h0001);
        check("rerun_pc", pc, 16'h0100);

        // Simultaneous halt and stall: halt wins
        drive(1, 1, 0, 0, 16'h0000, 0, 16'h0000);
        @(negedge clk);
        check("hs_state", {14'd0, state}, 16'h0003);
        check("hs_pc", pc, 16'h0100);
        check("hs_valid", {15'd0, pc_valid}, 16'h0000);
        drive(0, 0, 0, 0, 16'h0000, 0, 16'h0000);
        repeat (2) @(negedge clk);
        check("hs_sticky_state", {14'd0, state}, 16'h0003);
        check("hs_sticky_pc", pc, 16'h0100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
